d_latch_sync: RTL and testbench

//   Clock-domain-safe D-latch bank. Transparent while en=1 (q follows d

---
 rtl/d_latch_sync_pkg.sv | 23 ++
 rtl/en_sync2.sv | 36 +++
 rtl/d_latch_sync.sv | 119 +++++++++++
 tb/tb_d_latch_sync.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/d_latch_sync_pkg.sv
// -----------------------------------------------------------------------------
// d_latch_sync_pkg
//   Shared definitions for the d_latch_sync flop-based latch bank.
//   - DEF_WIDTH   : default data width of the latch bank.
//   - SYNC_STAGES : depth of the optional enable synchronizer.
//   - sel_q()     : per-bit output mux used for transparent mode.
//   Related configuration macro: D_LATCH_SYNC_SYNC_EN (see d_latch_sync.sv).
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

package d_latch_sync_pkg;

  localparam int DEF_WIDTH   = 1;
  localparam int SYNC_STAGES = 2;

  // Per-bit latch output mux. The conditional operator is used on purpose:
  // an X on en merges both sources instead of silently picking one, so X is
  // only hidden when both sources agree.
  function automatic logic sel_q(input logic en, input logic d, input logic held);
    return en ? d : held;
  endfunction

endpackage : d_latch_sync_pkg

// File: rtl/en_sync2.sv
// -----------------------------------------------------------------------------
// en_sync2
//   Two-flop synchronizer for a single-bit level signal. Both stages reset
//   asynchronously to 0, so the synchronized output reads 0 out of reset.
//   Only instantiated by d_latch_sync when D_LATCH_SYNC_SYNC_EN is defined.
// Ports:
//   clk    in   1  sampling clock, rising edge
//   rst_n  in   1  async active-low reset
//   d      in   1  asynchronous input level
//   q      out  1  synchronized level, SYNC_STAGES edges behind d
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

module en_sync2
  import d_latch_sync_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule : en_sync2

// File: rtl/d_latch_sync.sv
// -----------------------------------------------------------------------------
// d_latch_sync
//   Latch-semantics data bank built from flops. While en=1 the output is
//   transparent (q follows d combinationally); while en=0 it holds the value
//   captured at the last rising clock edge that saw en=1. The storage is a
//   plain flop bank, so timing analysis sees ordinary registers.
//
// Parameters:
//   WIDTH      data width in bits (>=1)
//   RESET_VAL  value loaded into the hold register on reset
//
// Ports:
//   clk      in   1      sampling clock, rising edge
//   rst_n    in   1      async active-low reset
//   d        in   WIDTH  data input
//   en       in   1      latch enable: 1 = transparent, 0 = hold
//   q        out  WIDTH  latch output
//   qn       out  WIDTH  bitwise complement of q
//   held     out  WIDTH  registered hold value
//   capture  out  1      1-cycle pulse on the cycle after en falls 1->0
//   changed  out  1      1-cycle pulse when held takes a new value
//
// Configuration macro D_LATCH_SYNC_SYNC_EN:
//   defined   -> en goes through a 2-flop synchronizer; q = held (fully
//                registered, no combinational d->q path).
//   undefined -> en is used directly; combinational transparency.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

module d_latch_sync
  import d_latch_sync_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] held,
  output logic             capture,
  output logic             changed
);

  // Enable actually used by the hold logic (raw or synchronized).
  logic             en_use_s;

  logic [WIDTH-1:0] held_r;
  logic [WIDTH-1:0] held_next_s;
  logic             en_q_r;
  logic             capture_r;
  logic             changed_r;
  // Set at the first edge after reset release; keeps the initial reload of
  // held from being reported as a change.
  logic             run_r;
  logic [WIDTH-1:0] q_s;

`ifdef D_LATCH_SYNC_SYNC_EN
  en_sync2 u_en_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (en),
    .q     (en_use_s)
  );
`else
  assign en_use_s = en;
`endif

  // Next hold value: follow d while enabled, otherwise keep the current value.
  // The conditional operator keeps an X enable visible downstream.
  always_comb begin
    held_next_s = held_r;
    held_next_s = en_use_s ? d : held_r;
  end

  // Hold register, enable history, capture and change pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_r    <= RESET_VAL;
      en_q_r    <= 1'b0;
      capture_r <= 1'b0;
      changed_r <= 1'b0;
      run_r     <= 1'b0;
    end else begin
      held_r    <= held_next_s;
      en_q_r    <= en_use_s;
      // en_q_r still holds the previous sample, so this fires on the first
      // edge that sees the enable low after it was high.
      capture_r <= en_q_r & ~en_use_s;
      changed_r <= run_r & (held_next_s != held_r);
      run_r     <= 1'b1;
    end
  end

  // Output mux. Reset forces the reset value onto q regardless of en/d.
  always_comb begin
    q_s = RESET_VAL;
    if (!rst_n) begin
      q_s = RESET_VAL;
    end else begin
`ifdef D_LATCH_SYNC_SYNC_EN
      q_s = held_r;
`else
      for (int i = 0; i < WIDTH; i++) begin
        q_s[i] = sel_q(en, d[i], held_r[i]);
      end
`endif
    end
  end

  assign q       = q_s;
  assign qn      = ~q_s;
  assign held    = held_r;
  assign capture = capture_r;
  assign changed = changed_r;

endmodule : d_latch_sync

// File: tb/tb_d_latch_sync.sv
// -----------------------------------------------------------------------------
// tb_d_latch_sync
//   Directed self-checking bench for d_latch_sync (WIDTH=1). Expected output
//   states are queued as each stimulus step is applied and popped when the
//   outputs are sampled. With D_LATCH_SYNC_SYNC_EN defined, the registered
//   (synchronized-enable) sequence runs instead of the transparent one.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

module tb_d_latch_sync;

  logic clk;
  logic rst_n;
  logic d;
  logic en;
  logic q;
  logic qn;
  logic held;
  logic capture;
  logic changed;

  typedef struct {
    string tag;
    logic  q;
    logic  held;
    logic  cap;
    logic  chg;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  d_latch_sync #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (d),
    .en      (en),
    .q       (q),
    .qn      (qn),
    .held    (held),
    .capture (capture),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic push_exp(input string tag, input logic eq, input logic eh,
                          input logic ec, input logic ech);
    exp_t e;
    e.tag  = tag;
    e.q    = eq;
    e.held = eh;
    e.cap  = ec;
    e.chg  = ech;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string field, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, field, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "q",       q,       e.q);
      cmp(e.tag, "qn",      qn,      ~e.q);
      cmp(e.tag, "held",    held,    e.held);
      cmp(e.tag, "capture", capture, e.cap);
      cmp(e.tag, "changed", changed, e.chg);
    end
  endtask

  // Wait for the next rising edge, then sample a little later.
  task automatic after_edge();
    @(posedge clk);
    #0.2;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    d     = 1'b0;
    #0.5;
    push_exp("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();

    // Release with d=0, en=0: q stays 0.
    @(negedge clk);
    rst_n = 1'b1;
    #0.2;
    push_exp("release_comb", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    after_edge();
    push_exp("release_edge", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();

`ifdef D_LATCH_SYNC_SYNC_EN
    // en rises with d=1: no combinational path, q follows after 3 edges.
    @(negedge clk);
    en = 1'b1;
    d  = 1'b1;
    #0.2;
    push_exp("sync_rise_comb", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    after_edge();
    push_exp("sync_edge1", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    after_edge();
    push_exp("sync_edge2", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    after_edge();
    push_exp("sync_edge3", 1'b1, 1'b1, 1'b0, 1'b1);
    check_out();

    // en falls; synchronized enable drops two edges later, capture one after.
    @(negedge clk);
    en = 1'b0;
    after_edge();
    push_exp("sync_fall_e1", 1'b1, 1'b1, 1'b0, 1'b0);
    check_out();
    after_edge();
    push_exp("sync_fall_e2", 1'b1, 1'b1, 1'b0, 1'b0);
    check_out();
    after_edge();
    push_exp("sync_capture", 1'b1, 1'b1, 1'b1, 1'b0);
    check_out();

    // d toggles while disabled: q and held unchanged.
    @(negedge clk);
    d = 1'b0;
    after_edge();
    push_exp("sync_hold_d0", 1'b1, 1'b1, 1'b0, 1'b0);
    check_out();
    @(negedge clk);
    d = 1'b1;
    after_edge();
    push_exp("sync_hold_d1", 1'b1, 1'b1, 1'b0, 1'b0);
    check_out();
`else
    // Transparent with d=0 for 10 time units, then d=1.
    @(negedge clk);
    en = 1'b1;
    d  = 1'b0;
    #0.2;
    push_exp("transp_d0", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    repeat (5) @(posedge clk);
    @(negedge clk);
    d = 1'b1;
    #0.2;
    push_exp("transp_d1_comb", 1'b1, 1'b0, 1'b0, 1'b0);
    check_out();
    after_edge();
    push_exp("transp_d1_edge", 1'b1, 1'b1, 1'b0, 1'b1);
    check_out();
    after_edge();
    push_exp("transp_d1_settle", 1'b1, 1'b1, 1'b0, 1'b0);
    check_out();

    // en falls and d changes in the same step: old value held, capture pulses.
    @(negedge clk);
    en = 1'b0;
    d  = 1'b0;
    #0.2;
    push_exp("fall_comb", 1'b1, 1'b1, 1'b0, 1'b0);
    check_out();
    after_edge();
    push_exp("fall_capture", 1'b1, 1'b1, 1'b1, 1'b0);
    check_out();
    after_edge();
    push_exp("fall_after", 1'b1, 1'b1, 1'b0, 1'b0);
    check_out();

    // Re-enable with d=0: q drops at once, held follows at the edge.
    @(negedge clk);
    en = 1'b1;
    #0.2;
    push_exp("reen_comb", 1'b0, 1'b1, 1'b0, 1'b0);
    check_out();
    after_edge();
    push_exp("reen_edge", 1'b0, 1'b0, 1'b0, 1'b1);
    check_out();
    after_edge();
    push_exp("reen_settle", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();

    // Async reset while transparent with d=1, then release.
    @(negedge clk);
    d = 1'b1;
    #0.2;
    push_exp("pre_reset_comb", 1'b1, 1'b0, 1'b0, 1'b0);
    check_out();
    rst_n = 1'b0;
    #0.2;
    push_exp("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    after_edge();
    push_exp("reset_edge", 1'b0, 1'b0, 1'b0, 1'b0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    #0.2;
    push_exp("rel_transp_comb", 1'b1, 1'b0, 1'b0, 1'b0);
    check_out();
    after_edge();
    push_exp("rel_transp_edge", 1'b1, 1'b1, 1'b0, 1'b0);
    check_out();
`endif

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_d_latch_sync
